// File: rtl/link_slot_scheduler.sv
// Time-shares one fixed-latency link datapath among L/R audio and text requesters,
// tagging each issue so its result is routed back to the owner LAT cycles later.
module link_slot_scheduler #(
  parameter int DW           = 24,
  parameter int LAT          = 4,
  parameter int GAP          = 2,
  parameter int TXT_MAX_WAIT = 64
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [2:0]    req_i,
  input  logic [DW-1:0] req_data_l_i,
  input  logic [DW-1:0] req_data_r_i,
  input  logic [DW-1:0] req_data_t_i,
  output logic [2:0]    req_ack_o,
  output logic          dp_valid_o,
  output logic [DW-1:0] dp_data_o,
  output logic [1:0]    dp_tag_o,
  input  logic [DW-1:0] dp_result_i,
  output logic [2:0]    rsp_valid_o,
  output logic [DW-1:0] rsp_data_o,
  output logic          busy_o
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int WW = $clog2(TXT_MAX_WAIT + 1);

  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  logic [WW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [LAT-1:0]      stg_v_q;
  logic [LAT-1:0][1:0] stg_tag_q;
  logic [2:0]          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]       rsp_data_q, rsp_data_d;
  logic                slot_open;
  logic                txt_urgent;
  logic [2:0]          grant;

  // Gating with the reset level keeps every issue output at zero while reset is held.
  assign slot_open  = rst_n_i && (gap_cnt_q == '0);
  assign txt_urgent = req_i[2] && (wait_cnt_q >= WW'(TXT_MAX_WAIT));

  always_comb begin
    grant = 3'b000;
    if (slot_open) begin
      if (txt_urgent)      grant = 3'b100;
      else if (req_i[0])   grant = 3'b001;
      else if (req_i[1])   grant = 3'b010;
      else if (req_i[2])   grant = 3'b100;
    end
  end

  always_comb begin
    dp_data_o = '0;
    dp_tag_o  = 2'd0;
    if (grant[0]) begin
      dp_data_o = req_data_l_i;
      dp_tag_o  = 2'd0;
    end else if (grant[1]) begin
      dp_data_o = req_data_r_i;
      dp_tag_o  = 2'd1;
    end else if (grant[2]) begin
      dp_data_o = req_data_t_i;
      dp_tag_o  = 2'd2;
    end
  end

  assign dp_valid_o = |grant;
  assign req_ack_o  = grant;

  always_comb begin
    gap_cnt_d = '0;
    if (dp_valid_o)            gap_cnt_d = GW'(GAP - 1);
    else if (gap_cnt_q != '0)  gap_cnt_d = gap_cnt_q - GW'(1);
  end

  // A text ack clears the wait counter even when it would otherwise increment.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant[2] || !req_i[2])                  wait_cnt_d = '0;
    else if (wait_cnt_q < WW'(TXT_MAX_WAIT))    wait_cnt_d = wait_cnt_q + WW'(1);
  end

  // Tag 3 is never issued; if it reaches the output stage it is dropped silently.
  always_comb begin
    rsp_valid_d = 3'b000;
    rsp_data_d  = rsp_data_q;
    if (stg_v_q[LAT-1]) begin
      rsp_data_d = dp_result_i;
      if (stg_tag_q[LAT-1] != 2'd3) rsp_valid_d = 3'b001 << stg_tag_q[LAT-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gap_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      stg_v_q     <= '0;
      stg_tag_q   <= '0;
      rsp_valid_q <= 3'b000;
      rsp_data_q  <= '0;
    end else begin
      gap_cnt_q    <= gap_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      stg_v_q[0]   <= dp_valid_o;
      stg_tag_q[0] <= dp_tag_o;
      for (int i = 1; i < LAT; i++) begin
        stg_v_q[i]   <= stg_v_q[i-1];
        stg_tag_q[i] <= stg_tag_q[i-1];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = (gap_cnt_q != '0) || (|stg_v_q) || (|rsp_valid_q);

endmodule
